// File: rtl/mult_pkg.sv
// Shared definitions for the multiple-scan sequencer and its flag logic.
package mult_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Default scanned-value width and the matching counter width
    localparam int DEF_WIDTH = 5;
    localparam int CNT_W     = DEF_WIDTH + 1;

    // Flag vector layout
    localparam int NFLAGS = 5;
    localparam int F2     = 0;
    localparam int F3     = 1;
    localparam int F4     = 2;
    localparam int F5     = 3;
    localparam int F235   = 4;

    // True when v is an exact multiple of d (zero is a multiple of everything)
    function automatic logic is_mult(input logic [31:0] v, input logic [31:0] d);
        return (v % d) == 32'd0;
    endfunction

endpackage

// File: rtl/mult_flags_comb.sv
// Purely combinational divisibility flags for one WIDTH-bit value.
module mult_flags_comb
    import mult_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0]  num,
    output logic [NFLAGS-1:0] flags
);

    logic [31:0] num32;

    assign num32 = 32'(num);

    // Evaluate each divisibility rule; the 2*3*5 flag is the AND of its factors
    always_comb begin
        flags       = '0;
        flags[F2]   = is_mult(num32, 32'd2);
        flags[F3]   = is_mult(num32, 32'd3);
        flags[F4]   = is_mult(num32, 32'd4);
        flags[F5]   = is_mult(num32, 32'd5);
        flags[F235] = flags[F2] & flags[F3] & flags[F5];
    end

endmodule

// File: rtl/mult_scan_ctrl.sv
// Range sweeper: walks lo..hi one value per clock through mult_flags_comb
// and counts multiples of 2, 3, 4, 5 and 30. Start/busy/done handshake.
// Optional feature: define MULT_SCAN_PAUSE_EN to add a pause input that
// freezes the sweep while in SCAN.
module mult_scan_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef MULT_SCAN_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] cur_num,
    output logic             cur_valid,
    output logic [WIDTH:0]   cnt2,
    output logic [WIDTH:0]   cnt3,
    output logic [WIDTH:0]   cnt4,
    output logic [WIDTH:0]   cnt5,
    output logic [WIDTH:0]   cnt235
);

    localparam int CW = WIDTH + 1;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   num_q;
    logic [CW-1:0]      cnt_q [NFLAGS];
    logic [NFLAGS-1:0]  flags;
    logic               hold;
    logic               adv;
    logic               range_ok;
    logic               last;

`ifdef MULT_SCAN_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign range_ok = (lo <= hi);
    assign adv      = (state_q == SCAN) && !hold;
    assign last     = (num_q == hi_q);

    mult_flags_comb #(.WIDTH(WIDTH)) u_flags (
        .num   (num_q),
        .flags (flags)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; termination is by compare with hi,
    // so cur_num never wraps even when hi is the largest value
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cur_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = range_ok ? SCAN : ERR;
                end
            end
            SCAN: begin
                busy      = 1'b1;
                cur_valid = adv;
                if (adv && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Range capture, value stepping and hit counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_q <= '0;
            for (int i = 0; i < NFLAGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (state_q == IDLE && start) begin
                for (int i = 0; i < NFLAGS; i++) begin
                    cnt_q[i] <= '0;
                end
                if (range_ok) begin
                    hi_q  <= hi;
                    num_q <= lo;
                end
            end else if (adv) begin
                for (int i = 0; i < NFLAGS; i++) begin
                    cnt_q[i] <= cnt_q[i] + CW'(flags[i]);
                end
                if (!last) begin
                    num_q <= num_q + 1'b1;
                end
            end
        end
    end

    assign cur_num = num_q;
    assign cnt2    = cnt_q[F2];
    assign cnt3    = cnt_q[F3];
    assign cnt4    = cnt_q[F4];
    assign cnt5    = cnt_q[F5];
    assign cnt235  = cnt_q[F235];

endmodule

// File: tb/tb_mult_scan_ctrl.sv
// Scoreboard bench for mult_scan_ctrl: the stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on every done pulse.
// With MULT_SCAN_PAUSE_EN defined the pause scenario is also exercised.
module tb_mult_scan_ctrl;

    localparam int WIDTH = 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] cur_num;
    logic             cur_valid;
    logic [WIDTH:0]   cnt2, cnt3, cnt4, cnt5, cnt235;
`ifdef MULT_SCAN_PAUSE_EN
    logic             pause;
`endif

    mult_scan_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MULT_SCAN_PAUSE_EN
        .pause     (pause),
`endif
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cur_num   (cur_num),
        .cur_valid (cur_valid),
        .cnt2      (cnt2),
        .cnt3      (cnt3),
        .cnt4      (cnt4),
        .cnt5      (cnt5),
        .cnt235    (cnt235)
    );

    typedef struct {
        int lo;
        int done_at;
        int busy_n;
        int e_err;
        int c2, c3, c4, c5, c235;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   vidx     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: follows the sweep value and scores every done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            vidx     = 0;
        end else begin
            if (cur_valid && q.size() > 0) begin
                check("cur_num", int'(cur_num), q[0].lo + vidx);
                vidx++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("done_cycle", cyc, e.done_at);
                    check("err", int'(err), e.e_err);
                    check("busy_cycles", busy_cnt, e.busy_n);
                    check("cnt2", int'(cnt2), e.c2);
                    check("cnt3", int'(cnt3), e.c3);
                    check("cnt4", int'(cnt4), e.c4);
                    check("cnt5", int'(cnt5), e.c5);
                    check("cnt235", int'(cnt235), e.c235);
                end
                busy_cnt = 0;
                vidx     = 0;
            end
        end
    end

    // Called #1 after a posedge: pulses start and queues the expectation
    task automatic issue(input int l, input int h, input int c2v, input int c3v,
                         input int c4v, input int c5v, input int c235v, input int paused);
        exp_t e;
        e.lo     = l;
        e.e_err  = (l > h) ? 1 : 0;
        e.busy_n = e.e_err ? 0 : (h - l + 1 + paused);
        e.done_at = e.e_err ? (cyc + 1) : (cyc + h - l + 2 + paused);
        e.c2 = c2v; e.c3 = c3v; e.c4 = c4v; e.c5 = c5v; e.c235 = c235v;
        q.push_back(e);
        lo    = WIDTH'(l);
        hi    = WIDTH'(h);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("scan_timeout", 1, 0);
            q.delete();
        end
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_valid"}, int'(cur_valid), 0);
        check({tag, "_num"}, int'(cur_num), 0);
        check({tag, "_cnts"}, int'(cnt2) + int'(cnt3) + int'(cnt4) + int'(cnt5) + int'(cnt235), 0);
    endtask

    initial begin
        int c0;
        rst_n = 1'b0;
        start = 1'b0;
        lo    = '0;
        hi    = '0;
`ifdef MULT_SCAN_PAUSE_EN
        pause = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full sweep; lo/hi scribbled mid-scan must not matter
        issue(0, 31, 16, 11, 8, 7, 2, 0);
        lo = 5'd7;
        hi = 5'd9;
        wait_idle();

        // Upper tail of the range
        issue(25, 31, 3, 2, 1, 2, 1, 0);
        wait_idle();

        // Single value
        issue(6, 6, 1, 1, 0, 0, 0, 0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("hold_cnt2", int'(cnt2), 1);
        check("hold_cnt3", int'(cnt3), 1);

        // Range error: counts cleared, busy never set
        issue(10, 3, 0, 0, 0, 0, 0, 0);
        wait_idle();

        // Ignored restart at cycle 5, then reset at cycle 10
        c0 = cyc;
        issue(0, 31, 16, 11, 8, 7, 2, 0);
        while (cyc < c0 + 5) @(posedge clk);
        #1;
        lo    = 5'd0;
        hi    = 5'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < c0 + 10) @(posedge clk);
        #1;
        check("abort_mid_busy", int'(busy), 1);
        q.delete();
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_zero("abort");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal run after the abort
        issue(25, 31, 3, 2, 1, 2, 1, 0);
        wait_idle();

`ifdef MULT_SCAN_PAUSE_EN
        // Pause during cycles 4..7 of a full sweep
        issue(0, 31, 16, 11, 8, 7, 2, 4);
        repeat (3) @(posedge clk);
        #1;
        pause = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        pause = 1'b0;
        wait_idle();
`endif

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_scan_ctrl.md
Name: mult_scan_ctrl

Overview:
- Sequencer that sweeps a programmable range [lo, hi] of WIDTH-bit values through the divisibility-flag datapath, one value per clock.
- Accumulates hit counts for multiples of 2, 3, 4, 5 and of 2·3·5 over the range.
- Sits between a host or testbench register interface and the flag logic, with a start/busy/done handshake.

Parameters:
WIDTH, 5, bit width of scanned values; counters are WIDTH+1 bits.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
start  in  1  scan request, sampled in IDLE only
lo  in  WIDTH  first value of range, captured on accepted start
hi  in  WIDTH  last value of range (inclusive), captured on accepted start
busy  out  1  high while in SCAN
done  out  1  one-cycle pulse at end of scan or on range error
err  out  1  one-cycle pulse coincident with done when lo > hi
cur_num  out  WIDTH  value currently presented to flag logic
cur_valid  out  1  cur_num is being evaluated this cycle (equals busy)
cnt2, cnt3, cnt4, cnt5, cnt235  out  WIDTH+1 each  hit counts for the last scan

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset: state=IDLE; busy, done, err, cur_valid=0; cur_num=0; all counts=0. rst_n low mid-scan aborts immediately to these values.
- States and transitions:
  - IDLE -> SCAN on start=1 with lo<=hi: capture lo/hi, cur_num<=lo, clear all counts.
  - IDLE -> ERR on start=1 with lo>hi: counts cleared.
  - SCAN: each cycle, evaluate flags of cur_num combinationally and increment each count whose flag is set (registered).
    - cur_num != hi: cur_num<=cur_num+1.
    - cur_num == hi: -> DONE, cur_num held.
  - DONE: done=1 for one cycle, -> IDLE.
  - ERR: done=1 and err=1 for one cycle, -> IDLE.
- Flag rules:
  - mult2: bit0==0.
  - mult4: bits[1:0]==0.
  - mult3: num mod 3 == 0.
  - mult5: num mod 5 == 0.
  - mult235: mult2 & mult3 & mult5.
  - Zero counts as a multiple of all.
- Latency: N=hi-lo+1 values.
  - Start sampled at edge E0; SCAN occupies cycles 1..N.
  - done is high in cycle N+1; counts are final and stable from cycle N+1.
  - Next start is accepted at cycle N+2 at the earliest.
- Boundaries:
  - hi = 2^WIDTH-1: termination is by compare, so cur_num never wraps.
  - lo == hi: single-value scan, N=1.
  - start while in SCAN, DONE or ERR is ignored (not queued).
  - Counts hold after done until the next accepted start or reset.
  - Counters cannot overflow, since max N = 2^WIDTH fits in WIDTH+1 bits.
  - lo and hi changing during a scan have no effect.

Optional Feature:
- MULT_SCAN_PAUSE_EN defined: adds input port pause (1 bit).
  - In SCAN with pause=1: cur_num, counts and state hold; cur_valid=0, busy stays 1.
  - pause is ignored in IDLE, DONE and ERR.
  - Latency grows by the number of paused SCAN cycles.
- Undefined: no pause port; behaviour exactly as above.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE, SCAN, DONE, ERR);
  - localparam CNT_W = WIDTH+1;
  - flag index constants F2, F3, F4, F5, F235.
- One natural sub-module: mult_flags_comb, purely combinational.
  - Input: WIDTH-bit num.
  - Output: 5-bit flag vector, implemented with modulo operators generic in WIDTH.
- Controller contains the FSM, range registers and five counters.

Test Plan:
- Full sweep lo=0, hi=31 -> cnt2=16, cnt3=11, cnt4=8, cnt5=7, cnt235=2; done exactly in cycle 33 after start; busy high for 32 cycles; no cur_num wrap.
- lo=25, hi=31 -> cnt2=3, cnt3=2, cnt4=1, cnt5=2, cnt235=1; done in cycle 8.
- lo=hi=6 -> cnt2=1, cnt3=1, cnt4=0, cnt5=0, cnt235=0; one SCAN cycle; done in cycle 2.
- lo=10, hi=3 -> err=1 and done=1 in cycle 1; counts 0; busy never asserts.
- Start 0..31, re-pulse start at cycle 5 with lo=0, hi=0; then assert rst_n=0 at cycle 10 -> second start ignored; reset sets all outputs to 0 next cycle; a new start afterwards runs normally.
- With MULT_SCAN_PAUSE_EN: sweep 0..31 with pause high for cycles 4..7 -> counts match the full sweep; done in cycle 37.
